guess_ctrl: RTL and testbench



---
 rtl/guess_ctrl.sv | 70 +++++++
 tb/tb_guess_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/guess_ctrl.sv
// Number-guessing round controller: latches a secret from the LFSR on start,
// grades guesses as too high/too low, and ends the round on a win or when tries run out.
module guess_ctrl #(
  parameter int unsigned MAX_TRIES = 7,
  parameter int unsigned WIDTH     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rand_num,
  input  logic             start,
  input  logic             guess_valid,
  input  logic [WIDTH-1:0] guess,
  output logic             playing,
  output logic             hint_valid,
  output logic             too_high,
  output logic             too_low,
  output logic             win,
  output logic             lose,
  output logic [3:0]       tries,
  output logic [WIDTH-1:0] secret
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] WIN  = 2'd2;
  localparam logic [1:0] LOSE = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] secret_reg;
  logic [3:0]       tries_inc;

  assign tries_inc = tries + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      secret_reg <= '0;
      tries      <= '0;
      too_high   <= 1'b0;
      too_low    <= 1'b0;
      hint_valid <= 1'b0;
    end else begin
      hint_valid <= 1'b0;
      // start wins over a same-cycle guess in every state, dropping that guess
      if (start) begin
        secret_reg <= rand_num;
        tries      <= '0;
        too_high   <= 1'b0;
        too_low    <= 1'b0;
        state      <= PLAY;
      end else if (state == PLAY && guess_valid) begin
        hint_valid <= 1'b1;
        tries      <= tries_inc;
        too_high   <= (guess > secret_reg);
        too_low    <= (guess < secret_reg);
        if (guess == secret_reg)
          state <= WIN;
        else if (tries_inc == 4'(MAX_TRIES))
          state <= LOSE;
      end
    end
  end

  // Flags decode straight from the state register, so they change only on clock or reset
  assign playing = (state == PLAY);
  assign win     = (state == WIN);
  assign lose    = (state == LOSE);
  assign secret  = (win || lose) ? secret_reg : '0;

endmodule

// File: tb/tb_guess_ctrl.sv
// Directed bench for guess_ctrl: expected output vectors are queued with each
// stimulus step and compared against the DUT after the following clock edge.
module tb_guess_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] rand_num = '0;
  logic       start = 1'b0;
  logic       guess_valid = 1'b0;
  logic [5:0] guess = '0;
  logic       playing, hint_valid, too_high, too_low, win, lose;
  logic [3:0] tries;
  logic [5:0] secret;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  guess_ctrl #(.MAX_TRIES(7), .WIDTH(6)) dut (
    .clk(clk), .rst(rst), .rand_num(rand_num), .start(start),
    .guess_valid(guess_valid), .guess(guess), .playing(playing),
    .hint_valid(hint_valid), .too_high(too_high), .too_low(too_low),
    .win(win), .lose(lose), .tries(tries), .secret(secret)
  );

  always #5 clk = ~clk;

  // Expected vector layout: {playing, hint_valid, too_high, too_low, win, lose, tries[3:0], secret[5:0]}
  task automatic expect_out(input string tag, input bit p, input bit h, input bit th,
                            input bit tl, input bit w, input bit l,
                            input logic [3:0] t, input logic [5:0] s);
    exp_q.push_back({p, h, th, tl, w, l, t, s});
    tag_q.push_back(tag);
  endtask

  task automatic check_now();
    logic [15:0] obs;
    logic [15:0] expv;
    string       tag;
    obs  = {playing, hint_valid, too_high, too_low, win, lose, tries, secret};
    expv = exp_q.pop_front();
    tag  = tag_q.pop_front();
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus, clock it, then compare against the queued expectation.
  task automatic cyc(input bit st, input bit gv, input logic [5:0] g, input logic [5:0] rn);
    start       = st;
    guess_valid = gv;
    guess       = g;
    rand_num    = rn;
    @(posedge clk);
    #1;
    start       = 1'b0;
    guess_valid = 1'b0;
    check_now();
  endtask

  initial begin
    #3;
    expect_out("reset_state", 0, 0, 0, 0, 0, 0, 4'd0, 6'd0);
    check_now();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Round 1: secret 37, high / low / correct
    expect_out("start37", 1, 0, 0, 0, 0, 0, 4'd0, 6'd0);
    cyc(1, 0, 6'd0, 6'd37);
    expect_out("g50_high", 1, 1, 1, 0, 0, 0, 4'd1, 6'd0);
    cyc(0, 1, 6'd50, 6'd1);
    expect_out("hint_hold", 1, 0, 1, 0, 0, 0, 4'd1, 6'd0);
    cyc(0, 0, 6'd0, 6'd2);
    expect_out("g20_low", 1, 1, 0, 1, 0, 0, 4'd2, 6'd0);
    cyc(0, 1, 6'd20, 6'd3);
    expect_out("g37_win", 0, 1, 0, 0, 1, 0, 4'd3, 6'd37);
    cyc(0, 1, 6'd37, 6'd4);
    expect_out("win_ignores_guess", 0, 0, 0, 0, 1, 0, 4'd3, 6'd37);
    cyc(0, 1, 6'd1, 6'd5);

    // Round 2: secret 10, seven wrong guesses lose
    expect_out("start10", 1, 0, 0, 0, 0, 0, 4'd0, 6'd0);
    cyc(1, 0, 6'd0, 6'd10);
    for (int i = 1; i <= 6; i++) begin
      expect_out($sformatf("g11_try%0d", i), 1, 1, 1, 0, 0, 0, 4'(i), 6'd0);
      cyc(0, 1, 6'd11, 6'd0);
    end
    expect_out("g11_lose", 0, 1, 1, 0, 0, 1, 4'd7, 6'd10);
    cyc(0, 1, 6'd11, 6'd0);
    expect_out("lose_ignores_guess", 0, 0, 1, 0, 0, 1, 4'd7, 6'd10);
    cyc(0, 1, 6'd11, 6'd0);

    // Round 3: start collides with a correct guess; start wins, guess dropped
    expect_out("restart10", 1, 0, 0, 0, 0, 0, 4'd0, 6'd0);
    cyc(1, 0, 6'd0, 6'd10);
    expect_out("start_beats_guess", 1, 0, 0, 0, 0, 0, 4'd0, 6'd0);
    cyc(1, 1, 6'd10, 6'd5);
    expect_out("new_secret5_win", 0, 1, 0, 0, 1, 0, 4'd1, 6'd5);
    cyc(0, 1, 6'd5, 6'd0);

    // Round 4: secret 63 won on the final allowed try
    expect_out("start63", 1, 0, 0, 0, 0, 0, 4'd0, 6'd0);
    cyc(1, 0, 6'd0, 6'd63);
    for (int i = 1; i <= 6; i++) begin
      expect_out($sformatf("g0_try%0d", i), 1, 1, 0, 1, 0, 0, 4'(i), 6'd0);
      cyc(0, 1, 6'd0, 6'd0);
    end
    expect_out("last_try_win", 0, 1, 0, 0, 1, 0, 4'd7, 6'd63);
    cyc(0, 1, 6'd63, 6'd0);

    // Round 5: secret 0 boundary
    expect_out("start0", 1, 0, 0, 0, 0, 0, 4'd0, 6'd0);
    cyc(1, 0, 6'd0, 6'd0);
    expect_out("g1_high_vs0", 1, 1, 1, 0, 0, 0, 4'd1, 6'd0);
    cyc(0, 1, 6'd1, 6'd9);
    expect_out("g0_win", 0, 1, 0, 0, 1, 0, 4'd2, 6'd0);
    cyc(0, 1, 6'd0, 6'd9);

    // Round 6: async reset mid-round at tries=4
    expect_out("start9", 1, 0, 0, 0, 0, 0, 4'd0, 6'd0);
    cyc(1, 0, 6'd0, 6'd9);
    for (int i = 1; i <= 4; i++) begin
      expect_out($sformatf("g3_try%0d", i), 1, 1, 0, 1, 0, 0, 4'(i), 6'd0);
      cyc(0, 1, 6'd3, 6'd0);
    end
    #1;
    rst = 1'b0;
    #1;
    expect_out("async_reset", 0, 0, 0, 0, 0, 0, 4'd0, 6'd0);
    check_now();
    @(posedge clk);
    #1;
    rst = 1'b1;
    expect_out("idle_ignores_guess", 0, 0, 0, 0, 0, 0, 4'd0, 6'd0);
    cyc(0, 1, 6'd9, 6'd9);
    expect_out("start_after_reset", 1, 0, 0, 0, 0, 0, 4'd0, 6'd0);
    cyc(1, 0, 6'd0, 6'd9);
    expect_out("g9_win_after_reset", 0, 1, 0, 0, 1, 0, 4'd1, 6'd9);
    cyc(0, 1, 6'd9, 6'd0);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: observed=%0d leftover expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
